// File: rtl/huff_serializer.sv
`default_nettype none
// ============================================================================
// Module   : huff_serializer
// Brief    : Buffered variable-length codeword to serial bitstream converter
//            with frame start/end marking and downstream backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module huff_serializer #(
    parameter int MAX_LEN   = 9,
    parameter int LEN_W     = 4,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_LEN-1:0] in_code,
    input  logic [LEN_W-1:0]   in_len,
    input  logic               in_last,
    output logic               out_bit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_start,
    output logic               out_done,
    output logic               err_len,
    output logic               busy
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    // The load step is folded into the IDLE->SHIFT edge so the first bit
    // appears one cycle after the entry lands in the FIFO.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [MAX_LEN-1:0] fifo_code_q [DEPTH];
    logic [LEN_W-1:0]   fifo_len_q  [DEPTH];
    logic               fifo_last_q [DEPTH];

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               err_len_q, err_len_d;
    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] code_q, code_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               start_pend_q, start_pend_d;

    logic               w_accept;
    logic               w_len_ok;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_shifting;
    logic               w_xfer;
    logic               w_last_bit;
    logic [LEN_W-1:0]   w_idx;
    logic [MAX_LEN-1:0] w_sel;

    always_comb begin
        w_accept   = in_valid & in_ready_q;
        w_len_ok   = (in_len != '0) && (in_len <= LEN_W'(MAX_LEN));
        w_push     = w_accept & w_len_ok;
        w_empty    = (count_q == '0);
        w_shifting = (state_q == SHIFT);
        w_xfer     = w_shifting & out_ready;
        w_last_bit = (cnt_q == '0);
        w_pop      = ~w_empty & (~w_shifting | (w_xfer & w_last_bit));
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_len_d  = w_accept & ~w_len_ok;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        in_ready_d = (count_d != CNT_W'(DEPTH));
    end

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        last_d       = last_q;
        start_pend_d = start_pend_q;
        if (w_pop) begin
            state_d      = SHIFT;
            code_d       = fifo_code_q[rd_ptr_q];
            len_d        = fifo_len_q[rd_ptr_q];
            cnt_d        = fifo_len_q[rd_ptr_q] - LEN_W'(1);
            first_d      = start_pend_q;
            last_d       = fifo_last_q[rd_ptr_q];
            start_pend_d = fifo_last_q[rd_ptr_q];
        end else if (w_xfer) begin
            if (w_last_bit) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_code_q[wr_ptr_q] <= in_code;
            fifo_len_q[wr_ptr_q]  <= in_len;
            fifo_last_q[wr_ptr_q] <= in_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b0;
            err_len_q    <= 1'b0;
            state_q      <= IDLE;
            code_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            start_pend_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            err_len_q    <= err_len_d;
            state_q      <= state_d;
            code_q       <= code_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            last_q       <= last_d;
            start_pend_q <= start_pend_d;
        end
    end

    // The counter always runs len-1 down to 0; bit order only changes which
    // code bit that count selects.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_idx = cnt_q;
        end else begin : g_lsb
            assign w_idx = len_q - LEN_W'(1) - cnt_q;
        end
    endgenerate

    assign w_sel     = code_q >> w_idx;
    assign out_bit   = w_shifting & w_sel[0];
    assign out_valid = w_shifting;
    assign out_start = w_shifting & first_q & (cnt_q == (len_q - LEN_W'(1)));
    assign out_done  = w_shifting & last_q & w_last_bit;
    assign in_ready  = in_ready_q;
    assign err_len   = err_len_q;
    assign busy      = ~w_empty | w_shifting;

endmodule
`default_nettype wire

// File: tb/tb_huff_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_huff_serializer
// Brief    : Directed bench for huff_serializer, MSB- and LSB-first instances
//            checked against a codeword-level bit-sequence model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_huff_serializer;

    localparam int MAX_LEN = 9;
    localparam int LEN_W   = 4;
    localparam int DEPTH   = 4;

    typedef struct packed {
        logic b;
        logic s;
        logic d;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [MAX_LEN-1:0] in_code = '0;
    logic [LEN_W-1:0]   in_len = '0;
    logic               in_last = 1'b0;
    logic               out_ready = 1'b1;

    logic rdy_m, ob_m, ov_m, os_m, od_m, err_m, busy_m;
    logic rdy_l, ob_l, ov_l, os_l, od_l, err_l, busy_l;

    always #5 clk = ~clk;

    huff_serializer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m), .in_code(in_code),
        .in_len(in_len), .in_last(in_last), .out_bit(ob_m), .out_valid(ov_m),
        .out_ready(out_ready), .out_start(os_m), .out_done(od_m), .err_len(err_m), .busy(busy_m)
    );

    huff_serializer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l), .in_code(in_code),
        .in_len(in_len), .in_last(in_last), .out_bit(ob_l), .out_valid(ov_l),
        .out_ready(out_ready), .out_start(os_l), .out_done(od_l), .err_len(err_l), .busy(busy_l)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected serial stream per instance, one entry per bit.
    exp_t q_m[$];
    exp_t q_l[$];
    logic start_pend = 1'b1;
    logic exp_err = 1'b0;
    int   cyc = 0;
    int   last_acc = 0;

    logic [31:0] cap_m = '0, cap_l = '0;
    int ncap_m = 0, ncap_l = 0, first_m = 0, last_m = 0;
    int nstart_m = 0, ndone_m = 0, nboth_m = 0, nboth_l = 0;
    int nerr_m = 0, nerr_l = 0, busy_fall = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            q_m.delete();
            q_l.delete();
            start_pend = 1'b1;
            exp_err    = 1'b0;
            check("rst_outs", {rdy_m, ov_m, os_m, od_m, err_m, busy_m, ob_m,
                               rdy_l, ov_l, os_l, od_l, err_l, busy_l, ob_l}, '0);
        end else begin
            check("err_len", {err_m, err_l}, {2{exp_err}});
            exp_err = 1'b0;
            if (err_m) nerr_m++;
            if (err_l) nerr_l++;
            if (!busy_m && prev_busy) busy_fall = cyc;

            if (ov_m) begin
                if (q_m.size() == 0) begin
                    check("m_spurious_valid", 1, 0);
                end else begin
                    check("m_bit_start_done", {ob_m, os_m, od_m}, q_m[0]);
                    if (out_ready) begin
                        void'(q_m.pop_front());
                        cap_m = {cap_m[30:0], ob_m};
                        if (ncap_m == 0) first_m = cyc;
                        last_m = cyc;
                        ncap_m++;
                        if (os_m) nstart_m++;
                        if (od_m) ndone_m++;
                        if (os_m && od_m) nboth_m++;
                    end
                end
            end else begin
                check("m_flags_unqualified", {os_m, od_m}, 2'b00);
            end

            if (ov_l) begin
                if (q_l.size() == 0) begin
                    check("l_spurious_valid", 1, 0);
                end else begin
                    check("l_bit_start_done", {ob_l, os_l, od_l}, q_l[0]);
                    if (out_ready) begin
                        void'(q_l.pop_front());
                        cap_l = {cap_l[30:0], ob_l};
                        ncap_l++;
                        if (os_l && od_l) nboth_l++;
                    end
                end
            end else begin
                check("l_flags_unqualified", {os_l, od_l}, 2'b00);
            end

            if (in_valid && rdy_m) begin
                last_acc = cyc;
                if (in_len >= 1 && in_len <= MAX_LEN) begin
                    for (int i = 0; i < int'(in_len); i++) begin
                        e.s = start_pend && (i == 0);
                        e.d = in_last && (i == int'(in_len) - 1);
                        e.b = in_code[int'(in_len) - 1 - i];
                        q_m.push_back(e);
                        e.b = in_code[i];
                        q_l.push_back(e);
                    end
                    start_pend = in_last;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
        prev_busy = busy_m;
    end

    task automatic clr();
        cap_m = '0; cap_l = '0; ncap_m = 0; ncap_l = 0;
        nstart_m = 0; ndone_m = 0; nboth_m = 0; nboth_l = 0;
        nerr_m = 0; nerr_l = 0;
    endtask

    // Called and returns at posedge+1; accepted at the returning edge.
    task automatic push(input logic [MAX_LEN-1:0] c, input logic [LEN_W-1:0] l, input logic la);
        int t = 0;
        in_valid = 1'b1; in_code = c; in_len = l; in_last = la;
        @(negedge clk);
        while (!rdy_m && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("push_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((q_m.size() != 0 || q_l.size() != 0 || busy_m || busy_l) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_drain_timeout"}, (t < 400), 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_bits(input int n);
        int t = 0;
        while (ncap_m < n && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("wait_bits_timeout", (t < 100), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", rdy_m, 1);
        check("idle_after_reset", {busy_m, ov_m, busy_l, ov_l}, 4'b0000);

        // 1: single 9-bit frame, latency and busy fall
        clr();
        push(9'b101100101, 4'd9, 1'b1);
        drain("t1");
        check("t1_msb_bits", cap_m[8:0], 9'b101100101);
        check("t1_lsb_bits", cap_l[8:0], 9'b101001101);
        check("t1_nbits", ncap_m, 9);
        check("t1_latency", first_m - last_acc, 2);
        check("t1_contiguous", last_m - first_m, 8);
        check("t1_busy_fall", busy_fall - last_m, 1);
        check("t1_start_done_cnt", {nstart_m[7:0], ndone_m[7:0]}, 16'h0101);

        // 2: back-to-back codewords, no bubble
        clr();
        push(9'h005, 4'd3, 1'b0);
        push(9'h1FD, 4'd2, 1'b1);
        drain("t2");
        check("t2_msb_bits", cap_m[4:0], 5'b10101);
        check("t2_lsb_bits", cap_l[4:0], 5'b10110);
        check("t2_no_bubble", last_m - first_m, 4);
        check("t2_start_done_cnt", {nstart_m[7:0], ndone_m[7:0]}, 16'h0101);

        // 3: stall mid-codeword and overfill the FIFO
        clr();
        push(9'h0B3, 4'd9, 1'b0);
        wait_bits(3);
        out_ready = 1'b0;
        push(9'h003, 4'd2, 1'b0);
        push(9'h155, 4'd9, 1'b0);
        push(9'h00C, 4'd4, 1'b0);
        push(9'h001, 4'd1, 1'b0);
        in_valid = 1'b1; in_code = 9'h0AA; in_len = 4'd8; in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_full_ready", rdy_m, 0);
            check("t3_hold_valid", {ov_m, ov_l}, 2'b11);
            check("t3_hold_bits", {ob_m, ob_l}, 2'b10);
        end
        check("t3_stalled_count", ncap_m, 3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(9'h0AA, 4'd8, 1'b1);
        drain("t3");
        check("t3_nbits", ncap_m, 33);
        check("t3_lsb_nbits", ncap_l, 33);

        // 4: illegal lengths dropped, their in_last ignored
        clr();
        push(9'h001, 4'd1, 1'b0);
        push(9'h1FF, 4'd0, 1'b1);
        push(9'h1FF, 4'd10, 1'b1);
        @(negedge clk);
        check("t4_ready_kept", rdy_m, 1);
        @(posedge clk); #1;
        push(9'h000, 4'd1, 1'b1);
        drain("t4");
        check("t4_err_cnt", {nerr_m[7:0], nerr_l[7:0]}, 16'h0202);
        check("t4_nbits", ncap_m, 2);
        check("t4_bits", cap_m[1:0], 2'b10);
        check("t4_start_done_cnt", {nstart_m[7:0], ndone_m[7:0]}, 16'h0101);

        // 5: bit order and single-bit frame
        clr();
        push(9'b000000110, 4'd3, 1'b1);
        drain("t5a");
        check("t5_lsb_bits", cap_l[2:0], 3'b011);
        check("t5_msb_bits", cap_m[2:0], 3'b110);
        clr();
        push(9'h1FE, 4'd1, 1'b1);
        drain("t5b");
        check("t5_single_both", {nboth_m[7:0], nboth_l[7:0]}, 16'h0101);
        check("t5_single_bit", {ncap_m[3:0], cap_m[0], cap_l[0]}, 6'b000100);

        // 6: reset during bit 4 with two codes queued
        clr();
        push(9'h1C7, 4'd9, 1'b0);
        push(9'h003, 4'd2, 1'b0);
        push(9'h005, 4'd3, 1'b1);
        wait_bits(3);
        rst = 1'b1;
        #1;
        check("t6_outs_on_reset", {ov_m, ob_m, os_m, od_m, busy_m, ov_l, busy_l}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_fifo_empty", {busy_m, busy_l, rdy_m}, 3'b001);
        clr();
        push(9'h002, 4'd2, 1'b1);
        drain("t6");
        check("t6_new_frame", {nstart_m[7:0], ndone_m[7:0]}, 16'h0101);
        check("t6_bits", {ncap_m[3:0], cap_m[1:0]}, 6'b001010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/huff_serializer.md
Name: huff_serializer

Overview:
- Parametrised, buffered successor of the team's Huffman parallel-to-serial converter.
- Accepts variable-length codewords over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Emits codewords one bit per transfer, MSB- or LSB-first, with back-to-back codewords carrying no idle bubbles.
- Sits between the Huffman code-table lookup and the bitstream output; handles downstream backpressure and frame start/end marking.

Parameters:
- MAX_LEN, 9: maximum codeword length in bits.
- LEN_W, 4: width of the length field; must satisfy 2^LEN_W > MAX_LEN.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- MSB_FIRST, 1: 1 = bit in_len-1 sent first; 0 = bit 0 sent first.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  codeword offered.
- in_ready  out  1  FIFO can accept.
- in_code  in  MAX_LEN  codeword; only the low in_len bits are meaningful.
- in_len  in  LEN_W  codeword length; legal range 1..MAX_LEN.
- in_last  in  1  codeword ends a frame.
- out_bit  out  1  serial data bit.
- out_valid  out  1  out_bit valid.
- out_ready  in  1  downstream accepts out_bit.
- out_start  out  1  high with the first bit of a frame.
- out_done  out  1  high with the last bit of a frame.
- err_len  out  1  one-cycle pulse when an illegal codeword is dropped.
- busy  out  1  FIFO non-empty or shifter active.

Behaviour:
- Reset (async, rst=1): FIFO empty, shifter idle, frame tracker at "start pending". All outputs 0 except in_ready. in_ready is 0 while rst=1 and 1 from the first cycle after release.
- Input handshake:
  - Accept when in_valid&in_ready at a clock edge.
  - in_ready = ~full; it is registered from FIFO count with no same-cycle pass-through from pop.
  - Push and pop in the same cycle leave the count unchanged.
- Illegal length (in_len=0 or in_len>MAX_LEN):
  - Handshake completes and the entry is discarded, including its in_last.
  - err_len pulses in the following cycle. FIFO is unchanged.
- Masking: bits of in_code at or above in_len never affect out_bit.
- Shifter states:
  - IDLE -> LOAD when the FIFO is non-empty: pop at the edge, set the bit counter to len-1, then go to SHIFT.
  - SHIFT: out_valid=1. Counter advances only on out_valid&out_ready.
  - On the last-bit transfer: if the FIFO is non-empty, reload at the same edge (stay in SHIFT, no gap); otherwise go to IDLE.
- Latency: a codeword accepted at edge N into an empty, idle block presents its first bit at cycle N+2 (after edge N+1).
- Backpressure: while out_valid&~out_ready, out_bit, out_start and out_done hold stable. No bit is lost or duplicated.
- Bit order:
  - MSB_FIRST=1: sequence in_code[len-1] … in_code[0].
  - MSB_FIRST=0: sequence in_code[0] … in_code[len-1].
- Frame marking:
  - out_start=1 on the first bit of the first codeword after reset or after a codeword tagged in_last.
  - out_done=1 on the last bit of a codeword tagged in_last.
  - A len-1 codeword that both starts and ends a frame asserts both in the same cycle.
  - Both are qualified by out_valid.
- busy = (count≠0) | (state≠IDLE).
- Reset mid-codeword: partial codeword and queued entries are lost. The next accepted codeword starts a new frame (out_start=1).

Test Plan:
1. MSB_FIRST=1, out_ready=1: push code 9'b101100101, len 9, last -> bits 1,0,1,1,0,0,1,0,1 on 9 consecutive cycles starting N+2; out_start on bit 1, out_done on bit 9; busy drops the cycle after.
2. Back-to-back: push (9'h005, len 3) then (9'h1FD, len 2, last) -> bits 1,0,1,0,1 contiguous with no bubble; out_start on bit 1 only, out_done on bit 5 only.
3. Backpressure/full: out_ready=0 for 3 cycles mid-codeword -> out_bit stable and the sequence resumes unchanged. Push DEPTH+1 codewords while stalled -> in_ready=0 once the FIFO is full, no entry lost, all bits delivered in order.
4. Illegal lengths: push len 0, then len 10 -> err_len pulses twice, out_valid stays 0, in_ready stays 1.
5. MSB_FIRST=0: push 9'b000000110, len 3, last -> bits 0,1,1; a single-bit code (len 1, last, fresh frame) asserts out_start and out_done together.
6. Assert rst during bit 4 of a 9-bit code with 2 codes queued -> outputs 0 immediately, FIFO empty; the next push produces out_start on its first bit.
